// File: rtl/des_key_schedule.sv
// des_key_schedule: iterative DES subkey generator (K1..K16), 1 or 2 rounds per clock.
// Optional weak-key flag is compiled in with `define DES_WEAKKEY_CHECK_EN.
module des_key_schedule #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
    output logic        busy,
    output logic        keys_valid,
    output logic [47:0] key00,
    output logic [47:0] key01,
    output logic [47:0] key02,
    output logic [47:0] key03,
    output logic [47:0] key04,
    output logic [47:0] key05,
    output logic [47:0] key06,
    output logic [47:0] key07,
    output logic [47:0] key08,
    output logic [47:0] key09,
    output logic [47:0] key10,
    output logic [47:0] key11,
    output logic [47:0] key12,
    output logic [47:0] key13,
    output logic [47:0] key14,
    output logic [47:0] key15
`ifdef DES_WEAKKEY_CHECK_EN
    ,
    output logic        weak_key
`endif
);
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
        $error("des_key_schedule: ROUNDS_PER_CYCLE must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

    // Tables use DES numbering: entry = 1-based source bit, bit 1 is the MSB.
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam logic [3:0] RSTEP  = 4'(ROUNDS_PER_CYCLE);
    localparam logic [3:0] LAST_R = 4'(16 - ROUNDS_PER_CYCLE);

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_T[i])];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
        return o;
    endfunction

    // Rounds 0,1,8,15 rotate by one; all others by two.
    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [3:0] r);
        if (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15) return {x[26:0], x[27]};
        return {x[25:0], x[27:26]};
    endfunction

    state_t             state_q, state_d;
    logic [63:0]        kin_q, kin_d;
    logic [27:0]        c_q, c_d, d_q, d_d;
    logic [3:0]         rnd_q, rnd_d, r1;
    logic               busy_q, busy_d, kv_q, kv_d;
    logic [15:0][47:0]  keys_q, keys_d;
    logic [27:0]        c1, d1, c2, d2;
    logic [47:0]        k1, k2;
    logic [55:0]        pc1_kin;
`ifdef DES_WEAKKEY_CHECK_EN
    logic               weak_q, weak_d;
`endif

    always_comb begin
        state_d = state_q;
        kin_d   = kin_q;
        c_d     = c_q;
        d_d     = d_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        kv_d    = kv_q;
        keys_d  = keys_q;
`ifdef DES_WEAKKEY_CHECK_EN
        weak_d  = weak_q;
`endif
        pc1_kin = pc1(kin_q);
        r1      = rnd_q + 4'd1;
        c1      = rotl(c_q, rnd_q);
        d1      = rotl(d_q, rnd_q);
        c2      = rotl(c1, r1);
        d2      = rotl(d1, r1);
        k1      = pc2({c1, d1});
        k2      = pc2({c2, d2});
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                kin_d   = key_in;
                kv_d    = 1'b0;
            end
            LOAD: begin
                c_d     = pc1_kin[55:28];
                d_d     = pc1_kin[27:0];
                rnd_d   = 4'd0;
                busy_d  = 1'b1;
                state_d = ROUND;
`ifdef DES_WEAKKEY_CHECK_EN
                weak_d  = (pc1_kin[55:28] == '0 || pc1_kin[55:28] == '1) &&
                          (pc1_kin[27:0]  == '0 || pc1_kin[27:0]  == '1);
`endif
            end
            ROUND: begin
                keys_d[rnd_q] = k1;
                if (ROUNDS_PER_CYCLE == 2) begin
                    keys_d[r1] = k2;
                    c_d = c2;
                    d_d = d2;
                end else begin
                    c_d = c1;
                    d_d = d1;
                end
                if (rnd_q == LAST_R) begin
                    rnd_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    rnd_d   = rnd_q + RSTEP;
                end
            end
            DONE: begin
                kv_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            kin_q   <= '0;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            kv_q    <= 1'b0;
            keys_q  <= '0;
`ifdef DES_WEAKKEY_CHECK_EN
            weak_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            kin_q   <= kin_d;
            c_q     <= c_d;
            d_q     <= d_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            kv_q    <= kv_d;
            keys_q  <= keys_d;
`ifdef DES_WEAKKEY_CHECK_EN
            weak_q  <= weak_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign keys_valid = kv_q;
    assign key00 = keys_q[0];
    assign key01 = keys_q[1];
    assign key02 = keys_q[2];
    assign key03 = keys_q[3];
    assign key04 = keys_q[4];
    assign key05 = keys_q[5];
    assign key06 = keys_q[6];
    assign key07 = keys_q[7];
    assign key08 = keys_q[8];
    assign key09 = keys_q[9];
    assign key10 = keys_q[10];
    assign key11 = keys_q[11];
    assign key12 = keys_q[12];
    assign key13 = keys_q[13];
    assign key14 = keys_q[14];
    assign key15 = keys_q[15];
`ifdef DES_WEAKKEY_CHECK_EN
    assign weak_key = weak_q;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed + random checks of des_key_schedule against a
// bit-numbered DES key-schedule model (cumulative rotation, table lookups).
module tb_des_key_schedule;
    localparam int RPC = 1;
    localparam int LAT = (RPC == 1) ? 18 : 10;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    logic        clk = 1'b0;
    logic        rst, start;
    logic [63:0] key_in;
    logic        busy, keys_valid;
    logic [47:0] key00, key01, key02, key03, key04, key05, key06, key07;
    logic [47:0] key08, key09, key10, key11, key12, key13, key14, key15;
`ifdef DES_WEAKKEY_CHECK_EN
    logic        weak_key;
`endif
    logic [767:0] all_keys;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    des_key_schedule #(.ROUNDS_PER_CYCLE(RPC)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .busy(busy), .keys_valid(keys_valid),
        .key00(key00), .key01(key01), .key02(key02), .key03(key03),
        .key04(key04), .key05(key05), .key06(key06), .key07(key07),
        .key08(key08), .key09(key09), .key10(key10), .key11(key11),
        .key12(key12), .key13(key13), .key14(key14), .key15(key15)
`ifdef DES_WEAKKEY_CHECK_EN
        , .weak_key(weak_key)
`endif
    );

    assign all_keys = {key00, key01, key02, key03, key04, key05, key06, key07,
                       key08, key09, key10, key11, key12, key13, key14, key15};

    // Subkey r = PC-2 of (C,D) rotated left by the running total of shifts 0..r.
    function automatic logic [767:0] model(input logic [63:0] k);
        logic [767:0] r;
        logic [27:0]  c, d;
        int s, p;
        r = '0;
        for (int i = 0; i < 28; i++) begin
            c[5'(i)] = k[6'(64 - PC1[i])];
            d[5'(i)] = k[6'(64 - PC1[28 + i])];
        end
        s = 0;
        for (int rr = 0; rr < 16; rr++) begin
            s += (rr == 0 || rr == 1 || rr == 8 || rr == 15) ? 1 : 2;
            for (int j = 0; j < 48; j++) begin
                p = PC2[j] - 1;
                r[10'(767 - rr * 48 - j)] = (p < 28) ? c[5'((p + s) % 28)]
                                                     : d[5'((p - 28 + s) % 28)];
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [63:0] k);
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        key_in = {$urandom, $urandom};
    endtask

    // Counts edges since the accepting edge until keys_valid; busy must hold meanwhile.
    task automatic wait_valid(input int n0, output int n, output bit busy_ok);
        n = n0;
        busy_ok = 1'b1;
        while (n < 60) begin
            tick();
            n++;
            if (keys_valid) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int n, rises;
        bit bok, pkv, seen;
        logic [767:0] exp2;
        logic [63:0]  ka, kb;

        rst = 1'b0; start = 1'b0; key_in = '0;
        #2 rst = 1'b1;
        tick(); tick();
        chk("rst_busy", 768'(busy), 768'(0));
        chk("rst_valid", 768'(keys_valid), 768'(0));
        chk("rst_keys", all_keys, '0);
`ifdef DES_WEAKKEY_CHECK_EN
        chk("rst_weak", 768'(weak_key), 768'(0));
`endif
        rst = 1'b0;
        tick();

        // Known-answer key
        exp2 = model(64'h133457799BBCDFF1);
        start_run(64'h133457799BBCDFF1);
        chk("kat_busy_n", 768'(busy), 768'(0));
        wait_valid(0, n, bok);
        chk("kat_latency", 768'(n), 768'(LAT));
        chk("kat_busy_during", 768'(bok), 768'(1));
        chk("kat_busy_after", 768'(busy), 768'(0));
        chk("kat_key00", 768'(key00), 768'(48'h1B02EFFC7072));
        chk("kat_key01", 768'(key01), 768'(48'h79AED9DBC9E5));
        chk("kat_key15", 768'(key15), 768'(48'hCB3D8B0E17F5));
        chk("kat_all", all_keys, exp2);
`ifdef DES_WEAKKEY_CHECK_EN
        chk("kat_weak", 768'(weak_key), 768'(0));
`endif
        tick(); tick();
        chk("kv_held_idle", 768'(keys_valid), 768'(1));

        // Parity-flipped key, restarted from IDLE with keys_valid high
        start_run(64'h123556789ABCDEF0);
        chk("restart_kv_drop", 768'(keys_valid), 768'(0));
        chk("restart_old_k15_a", 768'(key15), 768'(exp2[47:0]));
        tick(); tick();
        chk("restart_old_k15_b", 768'(key15), 768'(exp2[47:0]));
        wait_valid(2, n, bok);
        chk("parity_latency", 768'(n), 768'(LAT));
        chk("parity_all", all_keys, exp2);

        // start re-pulsed while busy with a different key
        ka = {$urandom, $urandom};
        kb = ~ka;
        start_run(ka);
        rises = 0; pkv = 1'b0;
        for (int c = 1; c < 40; c++) begin
            start  = (c == 3 || c == 9);
            key_in = kb;
            tick();
            if (keys_valid && !pkv) rises++;
            pkv = keys_valid;
        end
        start = 1'b0;
        chk("repulse_rises", 768'(rises), 768'(1));
        chk("repulse_keys", all_keys, model(ka));
        chk("repulse_busy", 768'(busy), 768'(0));

        // Random keys
        for (int t = 0; t < 5; t++) begin
            ka = {$urandom, $urandom};
            start_run(ka);
            wait_valid(0, n, bok);
            chk($sformatf("rnd%0d_latency", t), 768'(n), 768'(LAT));
            chk($sformatf("rnd%0d_busy", t), 768'(bok), 768'(1));
            chk($sformatf("rnd%0d_keys", t), all_keys, model(ka));
        end

        // Reset in the middle of the round sequence
        start_run({$urandom, $urandom});
        for (int c = 0; c < 8; c++) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 768'(busy), 768'(0));
        chk("abort_valid", 768'(keys_valid), 768'(0));
        chk("abort_keys", all_keys, '0);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (keys_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 768'(seen), 768'(0));
        start_run(64'h133457799BBCDFF1);
        wait_valid(0, n, bok);
        chk("post_abort_latency", 768'(n), 768'(LAT));
        chk("post_abort_keys", all_keys, exp2);

`ifdef DES_WEAKKEY_CHECK_EN
        start_run(64'h0101010101010101);
        wait_valid(0, n, bok);
        chk("weak0_flag", 768'(weak_key), 768'(1));
        chk("weak0_keys", all_keys, '0);
        start_run(64'hFEFEFEFEFEFEFEFE);
        wait_valid(0, n, bok);
        chk("weak1_flag", 768'(weak_key), 768'(1));
        chk("weak1_keys", all_keys, {768{1'b1}});
        start_run(64'h133457799BBCDFF1);
        wait_valid(0, n, bok);
        chk("strong_flag", 768'(weak_key), 768'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
